// File: rtl/pio_cq_completer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pio_cq_completer                                             |
// | Description : Endpoint memory-target completer. Accepts 1-DW MWr/MRd       |
// |               requests on a 64-bit CQ-style stream, writes/reads a local   |
// |               32-bit register RAM, returns read completions on a 64-bit    |
// |               CC-style stream, and rejects and counts unsupported ones.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pio_cq_completer #(
  parameter int ADDR_BITS = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 user_clk,
  input  logic                 user_reset,
  input  logic [63:0]          s_axis_cq_tdata,
  input  logic                 s_axis_cq_tvalid,
  input  logic                 s_axis_cq_tlast,
  output logic                 s_axis_cq_tready,
  output logic [63:0]          m_axis_cc_tdata,
  output logic [1:0]           m_axis_cc_tkeep,
  output logic                 m_axis_cc_tvalid,
  output logic                 m_axis_cc_tlast,
  input  logic                 m_axis_cc_tready,
  input  logic [15:0]          completer_id,
  output logic [ERR_CNT_W-1:0] unsupported_cnt,
  output logic                 busy
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DESC1    = 4'd1,
    WDATA    = 4'd2,
    RD_MEM   = 4'd3,
    CPL0     = 4'd4,
    CPL1     = 4'd5,
    ERR      = 4'd6,
    SINK     = 4'd7,
    DROP_CNT = 4'd8
  } state_t;

  localparam int DEPTH = 2 ** ADDR_BITS;

  state_t                state;
  state_t                state_nxt;

  // Captured request context
  logic [ADDR_BITS-1:0]  ram_idx;
  logic [4:0]            lower_addr;
  logic [15:0]           requester_id;
  logic [7:0]            tag;
  logic                  is_mrd;
  // Request failed validation; selects UR completion and SINK exit to ERR
  logic                  bad;

  logic [31:0]           mem [0:DEPTH-1];
  logic [31:0]           rdata;
  logic [ERR_CNT_W-1:0]  err_cnt;

  logic                  cq_fire;
  logic                  cc_fire;
  logic [10:0]           desc_dw_count;
  logic [3:0]            desc_type;
  logic                  desc_rd_ok;
  logic                  desc_wr_ok;
  logic                  ram_we;
  logic [31:0]           cpl_dw0;
  logic [31:0]           cpl_dw1;
  logic [31:0]           cpl_dw2;
  logic                  unused_bits;

  assign cq_fire       = s_axis_cq_tvalid && s_axis_cq_tready;
  assign cc_fire       = m_axis_cc_tvalid && m_axis_cc_tready;
  assign desc_dw_count = s_axis_cq_tdata[10:0];
  assign desc_type     = s_axis_cq_tdata[14:11];
  assign desc_rd_ok    = (desc_type == 4'd0) && (desc_dw_count == 11'd1) && s_axis_cq_tlast;
  assign desc_wr_ok    = (desc_type == 4'd1) && (desc_dw_count == 11'd1) && !s_axis_cq_tlast;
  assign ram_we        = (state == WDATA) && cq_fire;

  // Upper request bits beyond the descriptor fields carry nothing this block uses
  assign unused_bits   = ^s_axis_cq_tdata[63:40];

  // Completion header dwords; UR variant zeroes byte/dword counts and flags status
  assign cpl_dw0 = {3'b000, (bad ? 13'd0 : 13'd4), 9'b0, lower_addr, 2'b00};
  assign cpl_dw1 = {requester_id, 2'b00, (bad ? 3'b001 : 3'b000), (bad ? 11'd0 : 11'd1)};
  assign cpl_dw2 = {8'b0, completer_id, tag};

  assign unsupported_cnt = err_cnt;

  // State register
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stream outputs, decoded from the current state
  always_comb begin
    state_nxt        = state;
    s_axis_cq_tready = 1'b0;
    m_axis_cc_tdata  = 64'd0;
    m_axis_cc_tkeep  = 2'b00;
    m_axis_cc_tvalid = 1'b0;
    m_axis_cc_tlast  = 1'b0;
    busy             = (state != IDLE);
    case (state)
      IDLE: begin
        s_axis_cq_tready = 1'b1;
        if (cq_fire) begin
          state_nxt = s_axis_cq_tlast ? DROP_CNT : DESC1;
        end
      end
      DESC1: begin
        s_axis_cq_tready = 1'b1;
        if (cq_fire) begin
          if (desc_rd_ok) begin
            state_nxt = RD_MEM;
          end else if (desc_wr_ok) begin
            state_nxt = WDATA;
          end else if (s_axis_cq_tlast) begin
            state_nxt = ERR;
          end else begin
            state_nxt = SINK;
          end
        end
      end
      WDATA: begin
        s_axis_cq_tready = 1'b1;
        if (cq_fire) begin
          state_nxt = s_axis_cq_tlast ? IDLE : SINK;
        end
      end
      SINK: begin
        s_axis_cq_tready = 1'b1;
        if (cq_fire && s_axis_cq_tlast) begin
          state_nxt = bad ? ERR : IDLE;
        end
      end
      RD_MEM: begin
        state_nxt = CPL0;
      end
      CPL0: begin
        m_axis_cc_tvalid = 1'b1;
        m_axis_cc_tdata  = {cpl_dw1, cpl_dw0};
        m_axis_cc_tkeep  = 2'b11;
        if (cc_fire) begin
          state_nxt = CPL1;
        end
      end
      CPL1: begin
        m_axis_cc_tvalid = 1'b1;
        m_axis_cc_tlast  = 1'b1;
        if (bad) begin
          m_axis_cc_tdata = {32'd0, cpl_dw2};
          m_axis_cc_tkeep = 2'b01;
        end else begin
          m_axis_cc_tdata = {rdata, cpl_dw2};
          m_axis_cc_tkeep = 2'b11;
        end
        if (cc_fire) begin
          state_nxt = IDLE;
        end
      end
      ERR: begin
        state_nxt = is_mrd ? CPL0 : IDLE;
      end
      DROP_CNT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture request context as the header beats are accepted
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      ram_idx      <= '0;
      lower_addr   <= 5'd0;
      requester_id <= 16'd0;
      tag          <= 8'd0;
      is_mrd       <= 1'b0;
      bad          <= 1'b0;
    end else begin
      if ((state == IDLE) && cq_fire) begin
        ram_idx    <= s_axis_cq_tdata[ADDR_BITS+1:2];
        lower_addr <= s_axis_cq_tdata[6:2];
        bad        <= 1'b0;
      end
      if ((state == DESC1) && cq_fire) begin
        requester_id <= s_axis_cq_tdata[31:16];
        tag          <= s_axis_cq_tdata[39:32];
        is_mrd       <= (desc_type == 4'd0);
        bad          <= !(desc_rd_ok || desc_wr_ok);
      end
    end
  end

  // Saturating count of rejected requests
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      err_cnt <= '0;
    end else if ((state == ERR) || (state == DROP_CNT)) begin
      if (err_cnt != {ERR_CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  // Register RAM: contents survive reset; read data registered in RD_MEM
  always_ff @(posedge user_clk) begin
    if (ram_we) begin
      mem[ram_idx] <= s_axis_cq_tdata[31:0];
    end
    if (state == RD_MEM) begin
      rdata <= mem[ram_idx];
    end
  end

endmodule
`default_nettype wire
